mvu_pe_acc: RTL and testbench
=============================

Name: mvu_pe_acc

Overview:
- Downstream stage of the per-PE SIMD multiplier array in the MVU stream path.
- Takes SIMD packed products each valid beat and reduces them with a registered adder tree.
- Accumulates the reduced sums over SF beats (one synapse fold) and emits one PE output per fold with a single-cycle valid pulse.
- One instance per PE; the output feeds the MVU output packing stage.

Parameters:
- SIMD, 2, number of products per beat (>=1).
- TDstI, 16, product width, and also the accumulator and output width.
- SF, 4, beats per fold (>=1).
- OP_SGN, 0, operand sign mode. 0 = products unsigned. 1/2/3 = products signed two's complement.

Ports:
- aclk  input  1  clock, rising edge.
- aresetn  input  1  asynchronous active-low reset.
- in_clr  input  1  synchronous flush; discards any partial fold.
- in_v  input  1  product beat valid.
- in_simd  input  SIMD*TDstI  packed products; lane i = bits [i*TDstI +: TDstI].
- out_v  output  1  one-cycle pulse: out_acc holds a completed fold.
- out_acc  output  TDstI  accumulated fold result.

Behaviour:
- Reset (aresetn=0, async): sum_r, acc_r, sf_cnt, s1_v, s1_first, s1_last, out_v all 0; out_acc = 0. Reset mid-fold discards the fold; the first post-reset valid beat starts a new fold.
- Stage 1, every aclk edge:
  - s1_v <= in_v & ~in_clr.
  - If in_v: sum_r <= sum of all SIMD lanes modulo 2^TDstI. OP_SGN=0 treats lanes as unsigned, otherwise signed; same bits for wrap mode.
  - s1_first <= (sf_cnt==0); s1_last <= (sf_cnt==SF-1).
- sf_cnt (range 0..SF-1):
  - in_clr -> 0.
  - Else if in_v: wraps SF-1 -> 0, otherwise +1.
  - No change when in_v=0; gaps between beats are allowed with no timeout.
- Stage 2, when s1_v & ~in_clr:
  - acc_r <= s1_first ? sum_r : acc_r + sum_r.
  - out_v <= s1_last.
  - Otherwise out_v <= 0 and acc_r holds.
- out_acc = acc_r. Its value is meaningful only while out_v=1, and it holds until the next stage-2 update.
- Latency: last beat at edge t -> out_v=1 during the cycle after edge t+2, i.e. 2 cycles. Throughput: one beat per cycle, with back-to-back folds without bubbles.
- SF=1: every beat is both first and last; out_v follows in_v delayed by 2.
- in_clr:
  - Zeroes sf_cnt, s1_v and out_v at the next edge; acc_r holds.
  - A beat arriving with in_clr is dropped.
  - An in-flight stage-1 beat is dropped.
  - The next valid beat is the first beat of a new fold.
- No backpressure. The consumer must accept every out_v pulse.
- Arithmetic is wrap-around mod 2^TDstI unless the optional feature is enabled.

Optional Feature:
- Macro MVU_PE_ACC_SAT_EN.
- Defined:
  - Adder tree and accumulator are evaluated at TDstI+clog2(SIMD)+1 bits, then clamped to the TDstI range.
  - Unsigned range is [0, 2^TDstI-1]; signed range is [-2^(TDstI-1), 2^(TDstI-1)-1].
  - The accumulator saturates on each stage-2 update; timing is unchanged.
- Undefined: pure wrap-around as described above.

Test Plan:
- Reset / basic fold, SIMD=2, SF=4, OP_SGN=0. Release aresetn, then 4 consecutive beats with lanes {1,2},{3,4},{5,6},{7,8} -> out_v exactly one cycle, 2 cycles after the 4th beat, out_acc=36. out_v=0 during reset and elsewhere.
- Gapped beats, same config. Beats with in_v dropped for 3 cycles between each beat -> single out_v with out_acc=36; back-to-back second fold of {1,1}×4 -> out_acc=8 with no bubble.
- Signed, OP_SGN=3, TDstI=16, SF=2. Beats {-3,5},{-10,1} -> out_acc=16'hFFF9 (-7).
- Flush: after 2 beats of a fold, assert in_clr together with a third beat. Then 4 beats of {1,0} -> exactly one out_v, out_acc=4.
- Async reset mid-fold: drop aresetn asynchronously between clock edges after beat 2 -> out_v/out_acc go 0 immediately. The next 4 beats complete a fresh fold.
- Wrap vs saturation, OP_SGN=0, TDstI=8, SF=2. Beats {200,50},{10,5} -> out_acc=9 without MVU_PE_ACC_SAT_EN; 255 with it.

Source files
------------

// File: rtl/mvu_pe_acc.sv
// mvu_pe_acc: per-PE adder tree plus synapse-fold accumulator of the MVU stream path.
// Optional build macro MVU_PE_ACC_SAT_EN selects saturating instead of wrap-around arithmetic.
module mvu_pe_acc #(
    parameter int SIMD   = 2,
    parameter int TDstI  = 16,
    parameter int SF     = 4,
    parameter int OP_SGN = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_clr,
    input  logic                    in_v,
    input  logic [SIMD*TDstI-1:0]   in_simd,
    output logic                    out_v,
    output logic [TDstI-1:0]        out_acc
);

    localparam int CW = (SF > 1) ? $clog2(SF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SF - 1);

    if (SIMD < 1 || SF < 1 || TDstI < 2 || OP_SGN < 0 || OP_SGN > 3) begin : g_bad_cfg
        $error("mvu_pe_acc: unsupported parameter set");
    end

    logic [TDstI-1:0] sum_r;
    logic [TDstI-1:0] acc_r;
    logic [CW-1:0]    sf_cnt_r;
    logic             s1_v_r;
    logic             s1_first_r;
    logic             s1_last_r;
    logic             out_v_r;
    logic [TDstI-1:0] sum_s;
    logic [TDstI-1:0] acc_sum_s;

`ifdef MVU_PE_ACC_SAT_EN
    localparam int  EW  = TDstI + $clog2(SIMD) + 1;
    localparam bit  SGN = (OP_SGN != 0);

    function automatic logic [EW-1:0] widen(input logic [TDstI-1:0] x);
        if (SGN) begin
            widen = {{(EW-TDstI){x[TDstI-1]}}, x};
        end else begin
            widen = {{(EW-TDstI){1'b0}}, x};
        end
    endfunction

    // Clamp an extended-width value back into the representable TDstI range.
    function automatic logic [TDstI-1:0] clamp(input logic [EW-1:0] x);
        if (SGN) begin
            if (!x[EW-1] && (|x[EW-2:TDstI-1])) begin
                clamp = {1'b0, {(TDstI-1){1'b1}}};
            end else if (x[EW-1] && !(&x[EW-2:TDstI-1])) begin
                clamp = {1'b1, {(TDstI-1){1'b0}}};
            end else begin
                clamp = x[TDstI-1:0];
            end
        end else begin
            if (|x[EW-1:TDstI]) begin
                clamp = {TDstI{1'b1}};
            end else begin
                clamp = x[TDstI-1:0];
            end
        end
    endfunction

    logic [EW-1:0] tree_s;

    // Extended-width lane reduction with saturation of the tree and accumulator results
    always_comb begin
        tree_s = {EW{1'b0}};
        for (int i = 0; i < SIMD; i++) begin
            tree_s = tree_s + widen(in_simd[i*TDstI +: TDstI]);
        end
        sum_s     = clamp(tree_s);
        acc_sum_s = clamp(widen(acc_r) + widen(sum_r));
    end
`else
    // Wrap-around lane reduction; signedness does not change the result bits
    always_comb begin
        sum_s = {TDstI{1'b0}};
        for (int i = 0; i < SIMD; i++) begin
            sum_s = sum_s + in_simd[i*TDstI +: TDstI];
        end
        acc_sum_s = acc_r + sum_r;
    end
`endif

    // Stage 1: register the reduced beat and tag its position within the fold
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sum_r      <= {TDstI{1'b0}};
            sf_cnt_r   <= {CW{1'b0}};
            s1_v_r     <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end else begin
            s1_v_r     <= in_v & ~in_clr;
            s1_first_r <= (sf_cnt_r == {CW{1'b0}});
            s1_last_r  <= (sf_cnt_r == CNT_LAST);
            if (in_v) begin
                sum_r <= sum_s;
            end
            if (in_clr) begin
                sf_cnt_r <= {CW{1'b0}};
            end else if (in_v) begin
                sf_cnt_r <= (sf_cnt_r == CNT_LAST) ? {CW{1'b0}} : sf_cnt_r + CW'(1'b1);
            end
        end
    end

    // Stage 2: fold accumulation; a flush kills the beat currently in stage 1
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_r   <= {TDstI{1'b0}};
            out_v_r <= 1'b0;
        end else if (s1_v_r && !in_clr) begin
            acc_r   <= s1_first_r ? sum_r : acc_sum_s;
            out_v_r <= s1_last_r;
        end else begin
            out_v_r <= 1'b0;
        end
    end

    assign out_v   = out_v_r;
    assign out_acc = acc_r;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Self-checking bench for mvu_pe_acc: four configurations share one stimulus stream.
module tb_mvu_pe_acc;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn, in_clr, in_v;
    int   l0, l1;
    logic [31:0] simd16;
    logic [15:0] simd8;
    assign simd16 = {l1[15:0], l0[15:0]};
    assign simd8  = {l1[7:0], l0[7:0]};

    logic [3:0]  v_o;
    logic [15:0] acc0, acc1;
    logic [7:0]  acc2, acc3;
    logic [15:0] acc_o [4];
    assign acc_o[0] = acc0;
    assign acc_o[1] = acc1;
    assign acc_o[2] = {8'h00, acc2};
    assign acc_o[3] = {8'h00, acc3};

    mvu_pe_acc #(.SIMD(2), .TDstI(16), .SF(4), .OP_SGN(0)) u0 (
        .aclk(aclk), .aresetn(aresetn), .in_clr(in_clr), .in_v(in_v),
        .in_simd(simd16), .out_v(v_o[0]), .out_acc(acc0));
    mvu_pe_acc #(.SIMD(2), .TDstI(16), .SF(2), .OP_SGN(3)) u1 (
        .aclk(aclk), .aresetn(aresetn), .in_clr(in_clr), .in_v(in_v),
        .in_simd(simd16), .out_v(v_o[1]), .out_acc(acc1));
    mvu_pe_acc #(.SIMD(2), .TDstI(8), .SF(2), .OP_SGN(0)) u2 (
        .aclk(aclk), .aresetn(aresetn), .in_clr(in_clr), .in_v(in_v),
        .in_simd(simd8), .out_v(v_o[2]), .out_acc(acc2));
    mvu_pe_acc #(.SIMD(2), .TDstI(8), .SF(1), .OP_SGN(1)) u3 (
        .aclk(aclk), .aresetn(aresetn), .in_clr(in_clr), .in_v(in_v),
        .in_simd(simd8), .out_v(v_o[3]), .out_acc(acc3));

    int cfg_w  [4] = '{16, 16, 8, 8};
    int cfg_sf [4] = '{4, 2, 2, 1};
    bit cfg_sg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reference model: one beat waits a cycle before joining its fold; folds reduce arithmetically.
    bit     pend_v   [4];
    longint pend_val [4];
    int     fold_n   [4];
    longint fold_acc [4];
    bit     exp_v    [4];
    longint exp_acc  [4];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit clr; bit v; int a; int b; bit ev; int eacc;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint lane_val(input int m, input int x);
        longint u;
        u = longint'(x) & ((longint'(1) << cfg_w[m]) - 1);
        if (cfg_sg[m] && u >= (longint'(1) << (cfg_w[m] - 1))) u = u - (longint'(1) << cfg_w[m]);
        return u;
    endfunction

    function automatic longint fit(input int m, input longint x);
`ifdef MVU_PE_ACC_SAT_EN
        longint lo, hi;
        lo = cfg_sg[m] ? -(longint'(1) << (cfg_w[m] - 1)) : 0;
        hi = cfg_sg[m] ? (longint'(1) << (cfg_w[m] - 1)) - 1 : (longint'(1) << cfg_w[m]) - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
`else
        return x;
`endif
    endfunction

    task automatic reset_model();
        for (int m = 0; m < 4; m++) begin
            pend_v[m] = 1'b0; pend_val[m] = 0; fold_n[m] = 0;
            fold_acc[m] = 0; exp_v[m] = 1'b0; exp_acc[m] = 0;
        end
    endtask

    task automatic model_edge(input int m, input bit clr, input bit v, input int a, input int b);
        exp_v[m] = 1'b0;
        if (pend_v[m] && !clr) begin
            fold_acc[m] = (fold_n[m] == 0) ? pend_val[m] : fit(m, fold_acc[m] + pend_val[m]);
            fold_n[m]++;
            if (fold_n[m] == cfg_sf[m]) begin
                exp_v[m] = 1'b1;
                exp_acc[m] = fold_acc[m];
                fold_n[m] = 0;
            end
        end
        if (clr) fold_n[m] = 0;
        pend_v[m]   = v && !clr;
        pend_val[m] = fit(m, lane_val(m, a) + lane_val(m, b));
    endtask

    task automatic step(input bit clr, input bit v, input int a, input int b);
        in_clr = clr; in_v = v; l0 = a; l1 = b;
        @(posedge aclk);
        for (int m = 0; m < 4; m++) model_edge(m, clr, v, a, b);
        #1;
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("model out_v dut%0d", m), longint'(v_o[m]), longint'(exp_v[m]));
            if (exp_v[m])
                chk($sformatf("model out_acc dut%0d", m), longint'(acc_o[m]),
                    exp_acc[m] & ((longint'(1) << cfg_w[m]) - 1));
        end
    endtask

    task automatic add(input bit clr, input bit v, input int a, input int b, input bit ev, input int eacc);
        vec_t r;
        r.clr = clr; r.v = v; r.a = a; r.b = b; r.ev = ev; r.eacc = eacc;
        tbl.push_back(r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int pulses;
        aresetn = 1'b0; in_clr = 1'b0; in_v = 1'b0; l0 = 0; l1 = 0;
        reset_model();
        repeat (3) @(posedge aclk);
        #1;
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("reset out_v dut%0d", m), longint'(v_o[m]), 0);
            chk($sformatf("reset out_acc dut%0d", m), longint'(acc_o[m]), 0);
        end
        @(negedge aclk) aresetn = 1'b1;

        // Basic fold, then gapped fold followed by a back-to-back fold
        add(0, 1, 1, 2, 0, 0); add(0, 1, 3, 4, 0, 0); add(0, 1, 5, 6, 0, 0); add(0, 1, 7, 8, 0, 0);
        add(0, 0, 0, 0, 1, 36); add(0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 2, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0);
        add(0, 1, 3, 4, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0);
        add(0, 1, 5, 6, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0);
        add(0, 1, 7, 8, 0, 0);
        add(0, 1, 1, 1, 1, 36);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 8); add(0, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].v, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d out_v", i), longint'(v_o[0]), longint'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d out_acc", i), longint'(acc_o[0]), longint'(tbl[i].eacc));
        end

        // Signed two-beat fold
        step(1, 0, 0, 0);
        step(0, 1, -3, 5); step(0, 1, -10, 1); step(0, 0, 0, 0);
        chk("signed out_v", longint'(v_o[1]), 1);
        chk("signed out_acc", longint'(acc_o[1]), 64'hFFF9);

        // Wrap-around versus saturation on the 8-bit instance
        step(1, 0, 0, 0);
        step(0, 1, 200, 50); step(0, 1, 10, 5); step(0, 0, 0, 0);
        chk("wrap_sat out_v", longint'(v_o[2]), 1);
`ifdef MVU_PE_ACC_SAT_EN
        chk("wrap_sat out_acc", longint'(acc_o[2]), 255);
`else
        chk("wrap_sat out_acc", longint'(acc_o[2]), 9);
`endif

        // SF=1: each beat is a whole fold
        step(0, 1, 3, 4); step(0, 0, 0, 0);
        chk("sf1 out_v", longint'(v_o[3]), 1);
        chk("sf1 out_acc", longint'(acc_o[3]), 7);

        // Flush in the middle of a fold, together with a beat
        step(1, 0, 0, 0);
        pulses = 0;
        step(0, 1, 5, 5); pulses += int'(v_o[0]);
        step(0, 1, 5, 5); pulses += int'(v_o[0]);
        step(1, 1, 5, 5); pulses += int'(v_o[0]);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 0); pulses += int'(v_o[0]);
        end
        step(0, 0, 0, 0); pulses += int'(v_o[0]);
        chk("flush out_v", longint'(v_o[0]), 1);
        chk("flush out_acc", longint'(acc_o[0]), 4);
        step(0, 0, 0, 0); pulses += int'(v_o[0]);
        step(0, 0, 0, 0); pulses += int'(v_o[0]);
        chk("flush pulse count", longint'(pulses), 1);

        // Asynchronous reset between edges, mid-fold
        step(1, 0, 0, 0);
        step(0, 1, 2, 3); step(0, 1, 2, 3);
        #2 aresetn = 1'b0;
        #1;
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("async rst out_v dut%0d", m), longint'(v_o[m]), 0);
            chk($sformatf("async rst out_acc dut%0d", m), longint'(acc_o[m]), 0);
        end
        reset_model();
        in_v = 1'b0;
        @(negedge aclk) aresetn = 1'b1;
        for (int k = 0; k < 4; k++) step(0, 1, 2, 3);
        step(0, 0, 0, 0);
        chk("post-reset fold out_v", longint'(v_o[0]), 1);
        chk("post-reset fold out_acc", longint'(acc_o[0]), 20);

        // Random traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        end
        repeat (3) step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
